// File: rtl/addsub_pkg.sv
// Shared types for the adder/subtractor result stage: skid-buffer state and per-entry flags.
package addsub_pkg;

    localparam int MIN_SIZE = 2;
    localparam int MIN_CNT_W = 1;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } skid_state_t;

    typedef struct packed {
        logic n;
        logic z;
        logic c;
        logic v;
        logic sat;
    } addsub_flags_t;

    function automatic bit size_ok(input int size, input int cnt_w);
        return (size >= MIN_SIZE) && (cnt_w >= MIN_CNT_W);
    endfunction

endpackage

// File: rtl/addsub_flag_gen.sv
// Combinational flag derivation for one adder result: N/Z/C/V plus optional clamp.
// Clamping on signed overflow is compiled in only when SATURATE_EN is defined.
module addsub_flag_gen
    import addsub_pkg::*;
#(
    parameter int SIZE = 4
) (
    input  logic [SIZE-1:0] in_sum,
    input  logic [SIZE-1:0] in_cout,
    input  logic            in_ctrl,
    output logic [SIZE-1:0] sum,
    output addsub_flags_t   flags
);

    if (!size_ok(SIZE, 1)) begin : g_size_chk
        $error("addsub_flag_gen: SIZE must be >= 2");
    end

    // Overflowed sum with MSB set means the true result was above signed max.
    function automatic logic signed [SIZE-1:0] sat_clamp(input logic wrapped_msb);
        logic signed [SIZE-1:0] lim;
        lim = wrapped_msb ? $signed({1'b0, {(SIZE-1){1'b1}}})
                          : $signed({1'b1, {(SIZE-1){1'b0}}});
        return lim;
    endfunction

    logic signed [SIZE-1:0] sum_s;
    logic                   ovf;
    logic                   cout_unused;

    assign cout_unused = ^in_cout;
    assign ovf         = in_cout[SIZE-1] ^ in_cout[SIZE-2];

    always_comb begin
        sum_s     = $signed(in_sum);
        flags.sat = 1'b0;
`ifdef SATURATE_EN
        if (ovf) begin
            sum_s     = sat_clamp(in_sum[SIZE-1]);
            flags.sat = 1'b1;
        end
`endif
        flags.v = ovf;
        // Subtract reports borrow, the inverse of the adder's carry out.
        flags.c = in_cout[SIZE-1] ^ in_ctrl;
        flags.n = sum_s[SIZE-1];
        flags.z = (sum_s == '0);
    end

    assign sum = sum_s;

endmodule

// File: rtl/addsub_result_stage.sv
// Registered output stage behind the ripple adder/subtractor: 2-entry skid buffer,
// stored N/Z/C/V flags and a saturating overflow counter. Honours SATURATE_EN.
module addsub_result_stage
    import addsub_pkg::*;
#(
    parameter int SIZE  = 4,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [SIZE-1:0]  in_sum,
    input  logic [SIZE-1:0]  in_cout,
    input  logic             in_ctrl,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [SIZE-1:0]  out_sum,
    output logic             out_n,
    output logic             out_z,
    output logic             out_c,
    output logic             out_v,
    output logic             out_sat,
    input  logic             ovf_clr,
    output logic [CNT_W-1:0] ovf_count
);

    if (!size_ok(SIZE, CNT_W)) begin : g_size_chk
        $error("addsub_result_stage: SIZE must be >= 2 and CNT_W >= 1");
    end

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    // ---- p0: capture-side flag generation ----
    logic [SIZE-1:0] cap_sum_p0;
    addsub_flags_t   cap_flg_p0;

    addsub_flag_gen #(
        .SIZE (SIZE)
    ) u_flag_gen (
        .in_sum  (in_sum),
        .in_cout (in_cout),
        .in_ctrl (in_ctrl),
        .sum     (cap_sum_p0),
        .flags   (cap_flg_p0)
    );

    // ---- p1: output head register and skid register ----
    skid_state_t     state;
    skid_state_t     nxt_state;
    logic            vld_p1;
    logic [SIZE-1:0] hd_sum_p1;
    addsub_flags_t   hd_flg_p1;
    logic [SIZE-1:0] sk_sum_p1;
    addsub_flags_t   sk_flg_p1;
    logic            push;
    logic            pop;
    logic            hd_load;
    logic            sk_load;

    assign push = in_valid & in_ready;
    assign pop  = vld_p1 & out_ready;

    always_comb begin
        nxt_state = state;
        hd_load   = 1'b0;
        sk_load   = 1'b0;
        case (state)
            EMPTY: begin
                if (push) begin
                    nxt_state = ONE;
                    hd_load   = 1'b1;
                end
            end
            ONE: begin
                if (push && pop) begin
                    hd_load = 1'b1;
                end else if (push) begin
                    nxt_state = FULL;
                    sk_load   = 1'b1;
                end else if (pop) begin
                    nxt_state = EMPTY;
                end
            end
            FULL: begin
                if (pop) begin
                    nxt_state = ONE;
                    hd_load   = 1'b1;
                end
            end
            default: nxt_state = EMPTY;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= EMPTY;
            in_ready  <= 1'b1;
            vld_p1    <= 1'b0;
            hd_sum_p1 <= '0;
            hd_flg_p1 <= '0;
        end else begin
            state    <= nxt_state;
            in_ready <= (nxt_state != FULL);
            vld_p1   <= (nxt_state != EMPTY);
            if (hd_load) begin
                // In FULL the older entry sits in the skid register and must go first.
                hd_sum_p1 <= (state == FULL) ? sk_sum_p1 : cap_sum_p0;
                hd_flg_p1 <= (state == FULL) ? sk_flg_p1 : cap_flg_p0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (sk_load) begin
            sk_sum_p1 <= cap_sum_p0;
            sk_flg_p1 <= cap_flg_p0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ovf_count <= '0;
        end else if (ovf_clr) begin
            ovf_count <= '0;
        end else if (push && cap_flg_p0.v && (ovf_count != CNT_MAX)) begin
            ovf_count <= ovf_count + 1'b1;
        end
    end

    assign out_valid = vld_p1;
    assign out_sum   = hd_sum_p1;
    assign out_n     = hd_flg_p1.n;
    assign out_z     = hd_flg_p1.z;
    assign out_c     = hd_flg_p1.c;
    assign out_v     = hd_flg_p1.v;
    assign out_sat   = hd_flg_p1.sat;

endmodule
